// File: rtl/bsg_nasti_pkg.sv
// Shared NASTI packet types, response codes and FSM state for the memory sequencer.
// Field widths here match the sequencer's default parameters.
package bsg_nasti_pkg;

  localparam int NASTI_ADDR_W = 32;
  localparam int NASTI_DATA_W = 64;
  localparam int NASTI_ID_W   = 5;
  localparam int NASTI_LEN_W  = 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic [NASTI_ID_W-1:0]   id;
    logic [NASTI_ADDR_W-1:0] addr;
    logic [NASTI_LEN_W-1:0]  len;
  } bsg_nasti_a_pkt;

  typedef struct packed {
    logic [NASTI_DATA_W-1:0]   data;
    logic [NASTI_DATA_W/8-1:0] strb;
    logic                      last;
  } bsg_nasti_w_pkt;

  typedef struct packed {
    logic [NASTI_ID_W-1:0] id;
    logic [1:0]            resp;
  } bsg_nasti_b_pkt;

  typedef struct packed {
    logic [NASTI_ID_W-1:0]   id;
    logic [NASTI_DATA_W-1:0] data;
    logic [1:0]              resp;
    logic                    last;
  } bsg_nasti_r_pkt;

  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'd0,
    SEQ_READ  = 2'd1,
    SEQ_WRITE = 2'd2,
    SEQ_WRESP = 2'd3
  } seq_state_e;

endpackage

// File: rtl/bsg_nasti_burst_addr_gen.sv
// Per-beat word address and beat counter for one INCR burst.
// Only the low 12 address bits advance, so a burst wraps inside its 4KB page.
module bsg_nasti_burst_addr_gen #(
  parameter int addr_width_p = 32,
  parameter int len_width_p  = 8,
  parameter int stride_lg_p  = 3,
  parameter int mem_aw_p     = 12
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    load_i,
  input  logic [addr_width_p-1:0] addr_i,
  input  logic [len_width_p-1:0]  len_i,
  input  logic                    step_i,
  output logic [mem_aw_p-1:0]     addr_o,
  output logic                    last_o
);

  localparam logic [11:0] STRIDE = 12'(1 << stride_lg_p);

  logic [addr_width_p-1:0] addr_q;
  logic [len_width_p-1:0]  len_q;
  logic [len_width_p-1:0]  cnt_q;

  assign addr_o = addr_q[stride_lg_p +: mem_aw_p];
  assign last_o = (cnt_q == len_q);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      addr_q <= '0;
      len_q  <= '0;
      cnt_q  <= '0;
    end else if (load_i) begin
      addr_q <= addr_i;
      len_q  <= len_i;
      cnt_q  <= '0;
    end else if (step_i) begin
      addr_q <= {addr_q[addr_width_p-1:12], addr_q[11:0] + STRIDE};
      // Saturate on the final beat so len=max never wraps back to beat 0.
      if (!last_o) cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/bsg_nasti_mem_sequencer.sv
// NASTI slave that serializes read/write bursts onto a single-ported 1-cycle SRAM port.
// Burst-level round-robin between AR and AW; R beats leave through a registered output slot.
module bsg_nasti_mem_sequencer
  import bsg_nasti_pkg::*;
#(
  parameter int addr_width_p = NASTI_ADDR_W,
  parameter int data_width_p = NASTI_DATA_W,
  parameter int id_width_p   = NASTI_ID_W,
  parameter int len_width_p  = NASTI_LEN_W,
  parameter int mem_els_p    = 4096
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          ar_v_i,
  input  bsg_nasti_a_pkt                ar_i,
  output logic                          ar_ready_o,
  input  logic                          aw_v_i,
  input  bsg_nasti_a_pkt                aw_i,
  output logic                          aw_ready_o,
  input  logic                          w_v_i,
  input  bsg_nasti_w_pkt                w_i,
  output logic                          w_ready_o,
  output logic                          b_v_o,
  output bsg_nasti_b_pkt                b_o,
  input  logic                          b_ready_i,
  output logic                          r_v_o,
  output bsg_nasti_r_pkt                r_o,
  input  logic                          r_ready_i,
  output logic                          mem_v_o,
  output logic                          mem_w_o,
  output logic [$clog2(mem_els_p)-1:0]  mem_addr_o,
  output logic [data_width_p-1:0]       mem_data_o,
  output logic [data_width_p/8-1:0]     mem_mask_o,
  input  logic                          mem_ready_i,
  input  logic [data_width_p-1:0]       mem_data_i
);

  localparam int STRIDE_LG = $clog2(data_width_p/8);
  localparam int MEM_AW    = $clog2(mem_els_p);

  seq_state_e              state_q;
  logic                    wr_prio_q;
  logic                    err_q;
  logic [id_width_p-1:0]   id_q;
  logic                    rd_issued_q;
  logic                    pend_q;
  logic                    pend_last_q;
  logic                    r_v_q;
  bsg_nasti_r_pkt          r_q;
  logic                    skid_v_q;
  bsg_nasti_r_pkt          skid_q;

  logic                    grant_r, grant_w;
  logic                    drain, r_free, rd_req, wr_req, fire, rd_fire;
  logic [1:0]              occ;
  logic [MEM_AW-1:0]       ag_addr;
  logic                    ag_last;
  bsg_nasti_r_pkt          rd_beat;

  assign grant_r = (state_q == SEQ_IDLE) & ~reset_i & ar_v_i & (~aw_v_i | ~wr_prio_q);
  assign grant_w = (state_q == SEQ_IDLE) & ~reset_i & aw_v_i & (~ar_v_i |  wr_prio_q);
  assign ar_ready_o = grant_r;
  assign aw_ready_o = grant_w;

  // Beats owed to the R side (output slot, skid slot, read in flight); a new read
  // is only issued when its data is guaranteed a landing slot next cycle.
  assign drain  = r_v_q & r_ready_i;
  assign r_free = ~r_v_q | drain;
  assign occ    = 2'(r_v_q) + 2'(skid_v_q) + 2'(pend_q);
  assign rd_req = (state_q == SEQ_READ) & ~rd_issued_q & ((occ - 2'(drain)) <= 2'd1);
  assign wr_req = (state_q == SEQ_WRITE) & w_v_i;

  assign mem_v_o    = rd_req | wr_req;
  assign mem_w_o    = (state_q == SEQ_WRITE);
  assign mem_addr_o = ag_addr;
  assign mem_data_o = w_i.data;
  assign mem_mask_o = w_i.strb;
  assign w_ready_o  = (state_q == SEQ_WRITE) & mem_ready_i;
  assign fire       = mem_v_o & mem_ready_i;
  assign rd_fire    = rd_req & mem_ready_i;

  assign rd_beat = '{id: id_q, data: mem_data_i, resp: RESP_OKAY, last: pend_last_q};
  assign r_v_o   = r_v_q;
  assign r_o     = r_q;
  assign b_v_o   = (state_q == SEQ_WRESP);
  assign b_o     = '{id: id_q, resp: (err_q ? RESP_SLVERR : RESP_OKAY)};

  bsg_nasti_burst_addr_gen #(
    .addr_width_p(addr_width_p),
    .len_width_p (len_width_p),
    .stride_lg_p (STRIDE_LG),
    .mem_aw_p    (MEM_AW)
  ) addr_gen (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .load_i (grant_r | grant_w),
    .addr_i (grant_w ? aw_i.addr : ar_i.addr),
    .len_i  (grant_w ? aw_i.len  : ar_i.len),
    .step_i (fire),
    .addr_o (ag_addr),
    .last_o (ag_last)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= SEQ_IDLE;
      wr_prio_q   <= 1'b0;
      err_q       <= 1'b0;
      id_q        <= '0;
      rd_issued_q <= 1'b0;
      pend_q      <= 1'b0;
      pend_last_q <= 1'b0;
      r_v_q       <= 1'b0;
      r_q         <= '0;
      skid_v_q    <= 1'b0;
      skid_q      <= '0;
    end else begin
      pend_q <= rd_fire;
      if (rd_fire) begin
        pend_last_q <= ag_last;
        if (ag_last) rd_issued_q <= 1'b1;
      end

      if (r_free) begin
        if (skid_v_q) begin
          r_q      <= skid_q;
          r_v_q    <= 1'b1;
          skid_v_q <= pend_q;
          if (pend_q) skid_q <= rd_beat;
        end else begin
          r_v_q <= pend_q;
          if (pend_q) r_q <= rd_beat;
        end
      end else if (pend_q) begin
        skid_v_q <= 1'b1;
        skid_q   <= rd_beat;
      end

      unique case (state_q)
        SEQ_IDLE: begin
          if (grant_r) begin
            id_q        <= ar_i.id;
            rd_issued_q <= 1'b0;
            wr_prio_q   <= ~wr_prio_q;
            state_q     <= SEQ_READ;
          end else if (grant_w) begin
            id_q      <= aw_i.id;
            err_q     <= 1'b0;
            wr_prio_q <= ~wr_prio_q;
            state_q   <= SEQ_WRITE;
          end
        end
        SEQ_READ: begin
          if (drain && r_q.last) state_q <= SEQ_IDLE;
        end
        SEQ_WRITE: begin
          if (fire) begin
            // A last flag that disagrees with the beat count is a protocol error,
            // but the burst still ends on whichever comes first.
            if (w_i.last != ag_last) err_q <= 1'b1;
            if (w_i.last || ag_last) state_q <= SEQ_WRESP;
          end
        end
        SEQ_WRESP: begin
          if (b_ready_i) begin
            err_q   <= 1'b0;
            state_q <= SEQ_IDLE;
          end
        end
        default: state_q <= SEQ_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bsg_nasti_mem_sequencer.sv
// Scoreboard bench: expectations queued at stimulus time, monitors pop on every handshake.
module tb_bsg_nasti_mem_sequencer;
  import bsg_nasti_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic ar_v_i, aw_v_i, w_v_i, b_ready_i, r_ready_i, mem_ready_i;
  bsg_nasti_a_pkt ar_i, aw_i;
  bsg_nasti_w_pkt w_i;
  logic ar_ready_o, aw_ready_o, w_ready_o, b_v_o, r_v_o, mem_v_o, mem_w_o;
  bsg_nasti_b_pkt b_o;
  bsg_nasti_r_pkt r_o;
  logic [11:0] mem_addr_o;
  logic [63:0] mem_data_o, mem_data_i;
  logic [7:0]  mem_mask_o;

  bsg_nasti_mem_sequencer dut (
    .clk_i(clk), .reset_i(rst),
    .ar_v_i(ar_v_i), .ar_i(ar_i), .ar_ready_o(ar_ready_o),
    .aw_v_i(aw_v_i), .aw_i(aw_i), .aw_ready_o(aw_ready_o),
    .w_v_i(w_v_i), .w_i(w_i), .w_ready_o(w_ready_o),
    .b_v_o(b_v_o), .b_o(b_o), .b_ready_i(b_ready_i),
    .r_v_o(r_v_o), .r_o(r_o), .r_ready_i(r_ready_i),
    .mem_v_o(mem_v_o), .mem_w_o(mem_w_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_mask_o(mem_mask_o),
    .mem_ready_i(mem_ready_i), .mem_data_i(mem_data_i)
  );

  typedef struct packed {
    logic        w;
    logic [11:0] addr;
    logic [63:0] data;
    logic [7:0]  mask;
  } mem_exp_t;

  mem_exp_t       mem_q[$];
  bsg_nasti_r_pkt r_exp_q[$];
  bsg_nasti_b_pkt b_exp_q[$];
  bit             grant_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit wr_prio_m = 1'b0;
  bit rand_mem = 1'b0;
  bit tog_r = 1'b0;
  bit rd_fire_n = 1'b0;
  logic [11:0] rd_addr_n = '0;
  mem_exp_t me;
  bsg_nasti_r_pkt re;
  bsg_nasti_b_pkt be;
  bit ge;

  function automatic logic [63:0] mem_word(input logic [11:0] a);
    return {20'hC0DE0, a, 20'hA5A5A, ~a};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  function automatic void exp_rd(input logic [4:0] id, input logic [11:0] w0, input int n);
    for (int i = 0; i < n; i++) begin
      logic [11:0] w;
      w = {w0[11:9], 9'(w0[8:0] + 9'(i))};
      mem_q.push_back('{w: 1'b0, addr: w, data: 64'h0, mask: 8'h0});
      r_exp_q.push_back('{id: id, data: mem_word(w), resp: RESP_OKAY, last: (i == n - 1)});
    end
  endfunction

  function automatic void exp_wr(input logic [11:0] w0, input int n,
                                 input logic [63:0] base, input logic [7:0] strb);
    for (int i = 0; i < n; i++)
      mem_q.push_back('{w: 1'b1, addr: w0 + 12'(i), data: base + 64'(i), mask: strb});
  endfunction

  function automatic void exp_b(input logic [4:0] id, input logic [1:0] resp);
    b_exp_q.push_back('{id: id, resp: resp});
  endfunction

  function automatic void exp_grant(input bit is_w);
    grant_q.push_back(is_w);
    wr_prio_m = ~wr_prio_m;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Memory, R-sink and mem-ready drivers; read data appears only in the cycle after a read fire.
  initial begin
    mem_ready_i = 1'b1;
    r_ready_i   = 1'b1;
    mem_data_i  = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_data_i  = rd_fire_n ? mem_word(rd_addr_n) : {$urandom, $urandom};
      mem_ready_i = rand_mem ? 1'($urandom_range(0, 1)) : 1'b1;
      r_ready_i   = tog_r ? ~r_ready_i : 1'b1;
    end
  end

  always @(negedge clk) begin
    rd_fire_n = 1'b0;
    if (!rst) begin
      if (mem_v_o && mem_ready_i) begin
        if (!mem_w_o) begin
          rd_fire_n = 1'b1;
          rd_addr_n = mem_addr_o;
        end
        if (mem_q.size() == 0) chk("mem_unexpected", 1, 0);
        else begin
          me = mem_q.pop_front();
          chk("mem_w", mem_w_o, me.w);
          chk("mem_addr", mem_addr_o, me.addr);
          if (me.w) begin
            chk("mem_data", mem_data_o, me.data);
            chk("mem_mask", mem_mask_o, me.mask);
          end
        end
      end
      if (r_v_o && r_ready_i) begin
        if (r_exp_q.size() == 0) chk("r_unexpected", 1, 0);
        else begin
          re = r_exp_q.pop_front();
          chk("r_beat", r_o, re);
        end
      end
      if (b_v_o && b_ready_i) begin
        if (b_exp_q.size() == 0) chk("b_unexpected", 1, 0);
        else begin
          be = b_exp_q.pop_front();
          chk("b_resp", b_o, be);
        end
      end
      if (ar_ready_o || aw_ready_o) begin
        chk("one_ready", ar_ready_o & aw_ready_o, 0);
        if ((ar_v_i && ar_ready_o) || (aw_v_i && aw_ready_o)) begin
          if (grant_q.size() == 0) chk("grant_unexpected", 1, 0);
          else begin
            ge = grant_q.pop_front();
            chk("grant_kind", aw_ready_o, ge);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_ar(input logic [4:0] id, input logic [31:0] addr, input logic [7:0] len,
                       output int hs);
    ar_i = '{id: id, addr: addr, len: len};
    ar_v_i = 1'b1;
    hs = -1;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (ar_ready_o) begin
        hs = cyc;
        break;
      end
    end
    if (hs < 0) chk("ar_timeout", 1, 0);
    tick();
    ar_v_i = 1'b0;
  endtask

  task automatic do_aw(input logic [4:0] id, input logic [31:0] addr, input logic [7:0] len);
    bit ok;
    aw_i = '{id: id, addr: addr, len: len};
    aw_v_i = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (aw_ready_o) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("aw_timeout", 1, 0);
    tick();
    aw_v_i = 1'b0;
  endtask

  task automatic do_w(input int n, input int last_at, input logic [63:0] base,
                      input logic [7:0] strb);
    for (int b = 0; b < n; b++) begin
      bit ok;
      w_i = '{data: base + 64'(b), strb: strb, last: (b == last_at)};
      w_v_i = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 500; i++) begin
        @(negedge clk);
        if (w_ready_o) begin
          ok = 1'b1;
          break;
        end
      end
      if (!ok) chk("w_timeout", 1, 0);
      tick();
    end
    w_v_i = 1'b0;
  endtask

  task automatic wait_drain(input string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (mem_q.size() == 0 && r_exp_q.size() == 0 && b_exp_q.size() == 0 &&
          grant_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      $display("FAIL drain_%s mem=%0d r=%0d b=%0d g=%0d", nm, mem_q.size(), r_exp_q.size(),
               b_exp_q.size(), grant_q.size());
      checks++;
      errors++;
    end
    tick();
    tick();
  endtask

  initial begin
    int hs;
    int lat;
    w_v_i = 1'b0;
    b_ready_i = 1'b1;
    ar_i = '0;
    aw_i = '0;
    w_i = '0;
    ar_v_i = 1'b1;
    aw_v_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ar_ready", ar_ready_o, 0);
    chk("rst_aw_ready", aw_ready_o, 0);
    chk("rst_w_ready", w_ready_o, 0);
    chk("rst_b_v", b_v_o, 0);
    chk("rst_r_v", r_v_o, 0);
    chk("rst_mem_v", mem_v_o, 0);
    ar_v_i = 1'b0;
    aw_v_i = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    // 4-beat read from 0x100: words 0x20..0x23
    exp_rd(5'd3, 12'h020, 4);
    exp_grant(1'b0);
    do_ar(5'd3, 32'h100, 8'd3, hs);
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (r_v_o) begin
        lat = cyc - hs;
        break;
      end
    end
    // r_v_o rises two edges after the handshake edge (which itself is hs+1)
    chk("r_first_lat", lat, 3);
    wait_drain("t1");

    // Simultaneous AR/AW; priority model toggles on every grant
    for (int rep = 0; rep < 4; rep++) begin
      if (wr_prio_m) begin
        exp_wr(12'h100 + 12'(rep * 4), 1, 64'hAB00 + 64'(rep), 8'hFF);
        exp_b(5'(8 + rep), RESP_OKAY);
        exp_grant(1'b1);
        exp_rd(5'(rep), 12'h080 + 12'(rep * 8), 2);
        exp_grant(1'b0);
      end else begin
        exp_rd(5'(rep), 12'h080 + 12'(rep * 8), 2);
        exp_grant(1'b0);
        exp_wr(12'h100 + 12'(rep * 4), 1, 64'hAB00 + 64'(rep), 8'hFF);
        exp_b(5'(8 + rep), RESP_OKAY);
        exp_grant(1'b1);
      end
      fork
        do_ar(5'(rep), 32'h400 + 32'(rep * 64), 8'd1, hs);
        begin
          do_aw(5'(8 + rep), 32'h800 + 32'(rep * 32), 8'd0);
          do_w(1, 0, 64'hAB00 + 64'(rep), 8'hFF);
        end
      join
    end
    wait_drain("t3");

    // Single-beat write, partial mask
    exp_wr(12'h000, 1, 64'h1122334455667788, 8'h0F);
    exp_b(5'd1, RESP_OKAY);
    exp_grant(1'b1);
    do_aw(5'd1, 32'h0, 8'd0);
    do_w(1, 0, 64'h1122334455667788, 8'h0F);
    wait_drain("t2");

    // Early last on beat 2 of 4: two writes, SLVERR held until b_ready
    b_ready_i = 1'b0;
    exp_wr(12'h008, 2, 64'h5000, 8'hFF);
    exp_b(5'd2, RESP_SLVERR);
    exp_grant(1'b1);
    do_aw(5'd2, 32'h40, 8'd3);
    do_w(2, 1, 64'h5000, 8'hFF);
    repeat (4) tick();
    chk("b_hold_vld", b_v_o, 1);
    chk("b_hold_resp", b_o.resp, RESP_SLVERR);
    chk("b_hold_id", b_o.id, 5'd2);
    b_ready_i = 1'b1;
    wait_drain("t4a");
    exp_wr(12'h010, 2, 64'h6000, 8'hF0);
    exp_b(5'd4, RESP_OKAY);
    exp_grant(1'b1);
    do_aw(5'd4, 32'h80, 8'd1);
    do_w(2, 1, 64'h6000, 8'hF0);
    wait_drain("t4b");
    // Missing last on the final beat still ends the burst, with SLVERR
    exp_wr(12'h020, 1, 64'h7000, 8'h3C);
    exp_b(5'd5, RESP_SLVERR);
    exp_grant(1'b1);
    do_aw(5'd5, 32'h100, 8'd0);
    do_w(1, -1, 64'h7000, 8'h3C);
    wait_drain("t4c");

    // 4KB wrap: 0xFF8 then 0x000 (word 0x1FF then 0x000)
    exp_rd(5'd6, 12'h1FF, 2);
    exp_grant(1'b0);
    do_ar(5'd6, 32'h0FF8, 8'd1, hs);
    wait_drain("t5");
    exp_rd(5'd9, 12'h003, 1);
    exp_grant(1'b0);
    do_ar(5'd9, 32'h18, 8'd0, hs);
    wait_drain("t5b");

    // Backpressure on both sides
    rand_mem = 1'b1;
    tog_r = 1'b1;
    exp_rd(5'd7, 12'h400, 8);
    exp_grant(1'b0);
    do_ar(5'd7, 32'h2000, 8'd7, hs);
    wait_drain("t6r");
    exp_wr(12'h600, 4, 64'h9000, 8'hAA);
    exp_b(5'd10, RESP_OKAY);
    exp_grant(1'b1);
    do_aw(5'd10, 32'h3000, 8'd3);
    do_w(4, 3, 64'h9000, 8'hAA);
    wait_drain("t6w");

    // Reset in the middle of a long read
    exp_rd(5'd11, 12'hA00, 16);
    exp_grant(1'b0);
    do_ar(5'd11, 32'h5000, 8'd15, hs);
    repeat (6) tick();
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_r_v", r_v_o, 0);
    chk("mid_rst_mem_v", mem_v_o, 0);
    chk("mid_rst_b_v", b_v_o, 0);
    chk("mid_rst_w_ready", w_ready_o, 0);
    mem_q.delete();
    r_exp_q.delete();
    b_exp_q.delete();
    grant_q.delete();
    wr_prio_m = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    exp_rd(5'd12, 12'h01E, 3);
    exp_grant(1'b0);
    do_ar(5'd12, 32'h0F0, 8'd2, hs);
    wait_drain("t6post");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
